// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the multi-cycle RV32I-subset controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // FSM state encoding
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC_R = 4'd2;
  localparam logic [3:0] ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_ADDR   = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WR = 4'd6;
  localparam logic [3:0] ST_WB_ALU = 4'd7;
  localparam logic [3:0] ST_WB_MEM = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_TRAP   = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [3:0] decode_target(input logic [6:0] opcode);
    case (opcode)
      OP_R:               decode_target = ST_EXEC_R;
      OP_I:               decode_target = ST_EXEC_I;
      OP_LOAD, OP_STORE:  decode_target = ST_ADDR;
      OP_BRANCH:          decode_target = ST_BRANCH;
      default:            decode_target = ST_TRAP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Controller <-> datapath bundle (IR/flags in, control word out).
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             mem_ready;
  logic             zero;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             retire;
  logic [CNT_W-1:0] retired_count;
  logic             illegal;

  modport master (
    input  instr, mem_ready, zero,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           retire, retired_count, illegal
  );

  modport slave (
    output instr, mem_ready, zero,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           retire, retired_count, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_output_decode
// Brief    : Combinational state/opcode decode to control word and next state.
// Revision : 1.0 - initial release
// ============================================================================
module mc_output_decode
  import cpu_pkg::*;
(
  input  logic [3:0] state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic [3:0] next_state
);

  always_comb begin
    ctrl       = CTRL_NONE;
    next_state = state;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = ST_DECODE;
        end
      end
      // Speculatively compute the branch target into ALUOut
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = decode_target(opcode);
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = ST_WB_ALU;
      end
      ST_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) next_state = ST_WB_MEM;
      end
      // RAM enable doubles as strobe, so mem_read stays high on writes
      ST_MEM_WR: begin
        ctrl.mem_read  = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          next_state  = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        next_state     = ST_FETCH;
      end
      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        next_state      = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
        ctrl.retire    = 1'b1;
        next_state     = ST_FETCH;
      end
      ST_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        next_state = ST_TRAP;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle sequencing FSM with retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic [CNT_W-1:0] r_count;
  logic             w_unused;

  assign w_unused = ^bus.instr[31:7];

  mc_output_decode u_decode (
    .state      (r_state),
    .opcode     (bus.instr[6:0]),
    .mem_ready  (bus.mem_ready),
    .zero       (bus.zero),
    .ctrl       (w_ctrl),
    .next_state (w_next_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_count <= '0;
    else if (w_ctrl.retire) r_count <= r_count + CNT_W'(1);
  end

  // Reset masks the whole control word so no write enable fires mid-abort
  assign w_out = rst ? CTRL_NONE : w_ctrl;

  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.iord          = w_out.iord;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_src        = w_out.pc_src;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op        = w_out.alu_op;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.mem_to_reg    = w_out.mem_to_reg;
  assign bus.retire        = w_out.retire;
  assign bus.illegal       = w_out.illegal;
  assign bus.retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed vector bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  import cpu_pkg::*;

  localparam int CNT_W = 4;

  typedef struct {
    logic             rst;
    logic             mem_ready;
    logic             zero;
    logic [6:0]       op;
    ctrl_t            exp;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t cw(input logic mr, mw, io, irw, pcw, pcs,
                               input logic [1:0] a, b, op,
                               input logic rw, m2r, ret, ill);
    ctrl_t c;
    c.mem_read = mr;  c.mem_write = mw; c.iord = io;  c.ir_write = irw;
    c.pc_write = pcw; c.pc_src = pcs;   c.alu_src_a = a; c.alu_src_b = b;
    c.alu_op = op;    c.reg_write = rw; c.mem_to_reg = m2r;
    c.retire = ret;   c.illegal = ill;
    return c;
  endfunction

  function automatic vec_t v(input logic r, mr, z, input logic [6:0] op,
                             input ctrl_t e, input int cnt);
    vec_t t;
    t.rst = r; t.mem_ready = mr; t.zero = z; t.op = op; t.exp = e;
    t.cnt = CNT_W'(cnt);
    return t;
  endfunction

  ctrl_t c_zero, c_fwait, c_fgo, c_dec, c_exr, c_exi, c_mrd, c_mww, c_mwg;
  ctrl_t c_wba, c_wbm, c_br1, c_br0, c_trp;

  // Inputs change just after a rising edge; outputs are checked on the falling edge
  task automatic step(input string name, input int idx, input vec_t t);
    ctrl_t act;
    rst           = t.rst;
    bus.mem_ready = t.mem_ready;
    bus.zero      = t.zero;
    bus.instr     = {25'($urandom()), t.op};
    @(negedge clk);
    act.mem_read = bus.mem_read;   act.mem_write = bus.mem_write;
    act.iord = bus.iord;           act.ir_write = bus.ir_write;
    act.pc_write = bus.pc_write;   act.pc_src = bus.pc_src;
    act.alu_src_a = bus.alu_src_a; act.alu_src_b = bus.alu_src_b;
    act.alu_op = bus.alu_op;       act.reg_write = bus.reg_write;
    act.mem_to_reg = bus.mem_to_reg; act.retire = bus.retire;
    act.illegal = bus.illegal;
    checks++;
    if (act !== t.exp) begin
      errors++;
      $display("FAIL %s[%0d] ctrl: got %h expected %h", name, idx, act, t.exp);
    end
    checks++;
    if (bus.retired_count !== t.cnt) begin
      errors++;
      $display("FAIL %s[%0d] retired_count: got %0d expected %0d",
               name, idx, bus.retired_count, t.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    bus.instr = '0;

    c_zero  = '0;
    c_fwait = cw(1,0,0,0,0,0, 2'b00,2'b01,2'b00, 0,0,0,0);
    c_fgo   = cw(1,0,0,1,1,0, 2'b00,2'b01,2'b00, 0,0,0,0);
    c_dec   = cw(0,0,0,0,0,0, 2'b10,2'b10,2'b00, 0,0,0,0);
    c_exr   = cw(0,0,0,0,0,0, 2'b01,2'b00,2'b10, 0,0,0,0);
    c_exi   = cw(0,0,0,0,0,0, 2'b01,2'b10,2'b00, 0,0,0,0);
    c_mrd   = cw(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    c_mww   = cw(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    c_mwg   = cw(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0);
    c_wba   = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,1,0);
    c_wbm   = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,1,1,0);
    c_br1   = cw(0,0,0,0,1,1, 2'b01,2'b00,2'b01, 0,0,1,0);
    c_br0   = cw(0,0,0,0,0,1, 2'b01,2'b00,2'b01, 0,0,1,0);
    c_trp   = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,1);

    // add
    tbl.push_back(v(1,1,0,OP_R,      c_zero, 0));
    tbl.push_back(v(0,1,0,OP_R,      c_fgo,  0));
    tbl.push_back(v(0,0,1,OP_R,      c_dec,  0));
    tbl.push_back(v(0,0,0,OP_R,      c_exr,  0));
    tbl.push_back(v(0,0,0,OP_R,      c_wba,  0));
    // lw, two wait cycles in MEM_RD
    tbl.push_back(v(0,1,0,OP_LOAD,   c_fgo,  1));
    tbl.push_back(v(0,1,0,OP_LOAD,   c_dec,  1));
    tbl.push_back(v(0,1,0,OP_LOAD,   c_exi,  1));
    tbl.push_back(v(0,0,0,OP_LOAD,   c_mrd,  1));
    tbl.push_back(v(0,0,1,OP_LOAD,   c_mrd,  1));
    tbl.push_back(v(0,1,0,OP_LOAD,   c_mrd,  1));
    tbl.push_back(v(0,0,0,OP_LOAD,   c_wbm,  1));
    // sw, one wait cycle in MEM_WR
    tbl.push_back(v(0,1,0,OP_STORE,  c_fgo,  2));
    tbl.push_back(v(0,1,0,OP_STORE,  c_dec,  2));
    tbl.push_back(v(0,1,0,OP_STORE,  c_exi,  2));
    tbl.push_back(v(0,0,0,OP_STORE,  c_mww,  2));
    tbl.push_back(v(0,1,0,OP_STORE,  c_mwg,  2));
    // beq taken / not taken
    tbl.push_back(v(0,1,0,OP_BRANCH, c_fgo,  3));
    tbl.push_back(v(0,1,0,OP_BRANCH, c_dec,  3));
    tbl.push_back(v(0,1,1,OP_BRANCH, c_br1,  3));
    tbl.push_back(v(0,1,1,OP_BRANCH, c_fgo,  4));
    tbl.push_back(v(0,1,1,OP_BRANCH, c_dec,  4));
    tbl.push_back(v(0,1,0,OP_BRANCH, c_br0,  4));
    // add with fetch wait, reset during WB_ALU
    tbl.push_back(v(0,0,0,OP_R,      c_fwait,5));
    tbl.push_back(v(0,1,0,OP_R,      c_fgo,  5));
    tbl.push_back(v(0,1,0,OP_R,      c_dec,  5));
    tbl.push_back(v(0,1,0,OP_R,      c_exr,  5));
    tbl.push_back(v(1,1,0,OP_R,      c_zero, 0));
    tbl.push_back(v(0,0,0,OP_R,      c_fwait,0));
    // addi, then illegal opcode
    tbl.push_back(v(0,1,0,OP_I,      c_fgo,  0));
    tbl.push_back(v(0,1,0,OP_I,      c_dec,  0));
    tbl.push_back(v(0,1,0,OP_I,      c_exi,  0));
    tbl.push_back(v(0,1,0,OP_I,      c_wba,  0));
    tbl.push_back(v(0,1,0,7'h7F,     c_fgo,  1));
    tbl.push_back(v(0,1,0,7'h7F,     c_dec,  1));
    tbl.push_back(v(0,1,0,7'h7F,     c_trp,  1));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step("table", i, tbl[i]);

    // TRAP is sticky regardless of inputs
    for (int i = 0; i < 20; i++)
      step("trap_hold", i, v(0, 1'($urandom()), 1'($urandom()), OP_R, c_trp, 1));
    step("trap_rst", 0, v(1,1,0,OP_R, c_zero,  0));
    step("trap_rst", 1, v(0,0,0,OP_R, c_fwait, 0));

    // 16 beq retirements wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      step("wrap", 3*i,   v(0,1,1,OP_BRANCH, c_fgo, i));
      step("wrap", 3*i+1, v(0,1,1,OP_BRANCH, c_dec, i));
      step("wrap", 3*i+2, v(0,1,1,OP_BRANCH, c_br1, i));
    end
    step("wrap_end", 0, v(0,0,0,OP_R, c_fwait, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
